ttl74193_stepper: RTL and testbench
===================================

Name: ttl74193_stepper

Overview:
- Initiator for the 74193 counter interface. It drives CPu, CPd, CLR, /LD and D..A so that a downstream ttl74193 instance reaches a requested 4-bit value.
- Keeps a shadow copy of the counter value.
- Picks the shorter direction around the mod-16 ring.
- Stretches every pulse so it survives the counter's input debounce.
- Sits between board-level control logic and the counter, replacing the physical buttons and switches.

Parameters:
- PULSE_LOW, 20000: clk cycles a count or load strobe is held active. Must be ≥1 and greater than the counter's debounce period.
- PULSE_GAP, 20000: clk cycles of idle-high between consecutive strobes. Must be ≥1.
- TMR_W, 20: width of the internal phase timer. Must hold max(PULSE_LOW, PULSE_GAP).

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle request to step the counter to target.
- target, input, 4: requested counter value, sampled with start.
- load_req, input, 1: one-cycle request to parallel-load load_val.
- load_val, input, 4: value to load, sampled with load_req.
- clr_req, input, 1: one-cycle request to clear the counter.
- q_fb, input, 4: counter QD..QA feedback. Used only with STEP_VERIFY_EN.
- cpu, output, 1: up-count strobe. Idle 1, active 0.
- cpd, output, 1: down-count strobe. Idle 1, active 0.
- clr, output, 1: counter clear. Active 1.
- ld, output, 1: counter load. Active 0.
- dcba, output, 4: parallel data {D,C,B,A}.
- cur, output, 4: shadow counter value.
- busy, output, 1: 1 whenever the FSM is not IDLE.
- done, output, 1: one-cycle completion pulse.
- err, output, 1: sticky step-mismatch flag. Tied 0 without STEP_VERIFY_EN.

Behaviour:
- Reset values: cpu=1, cpd=1, clr=0, ld=1, dcba=0, cur=0, busy=0, done=0, err=0. FSM goes to IDLE and the timer clears.
- Reset mid-operation aborts immediately. No completion pulse is produced.
- States: IDLE, CLR, LOAD, STROBE, GAP, DONE.
- IDLE: requests are sampled every cycle.
  - Priority is clr_req > load_req > start.
  - Lower-priority requests in the same cycle are dropped.
  - Requests arriving while busy=1 are ignored, not queued.
- clr_req: go to CLR.
  - clr=1 for PULSE_LOW cycles.
  - Then cur=0, go to GAP with remaining steps=0.
- load_req: dcba<=load_val, go to LOAD.
  - ld=0 for PULSE_LOW cycles.
  - Then cur=load_val, ld=1, go to GAP with steps=0.
  - dcba holds its value until the next load.
- start, direction choice:
  - up=(target-cur) mod 16, dn=(cur-target) mod 16.
  - If up≤dn, direction is up and steps=up; otherwise direction is down and steps=dn.
  - A tie (distance 8) goes up.
- start, sequencing:
  - steps=0 goes directly to DONE; no strobe is issued.
  - Otherwise go to STROBE.
  - All arithmetic is 4-bit with wrap: 15+1=0, 0-1=15.
- STROBE: the selected strobe (cpu or cpd) is 0 for exactly PULSE_LOW cycles; the other strobe stays 1.
  - At exit, the strobe returns to 1 and cur steps by ±1 with wrap.
  - steps decrements, then go to GAP.
- GAP: all strobes are inactive for PULSE_GAP cycles.
  - Then go to STROBE if steps≠0, else DONE.
- DONE: done=1 for one cycle, busy=0 from the next cycle, then IDLE.
- cpu and cpd are never 0 in the same cycle.
- clr and ld are never active in the same cycle.
- Latency for a start with steps=N≥1: done asserts N·(PULSE_LOW+PULSE_GAP)+1 cycles after the start cycle.

Optional Feature:
- STEP_VERIFY_EN defined:
  - In the last GAP cycle, q_fb is compared with cur.
  - On mismatch: err<=1 (sticky until rst), remaining steps are abandoned, and the FSM goes to DONE.
- STEP_VERIFY_EN undefined: q_fb is unused and err is constant 0.

Test Plan (PULSE_LOW=3, PULSE_GAP=2):
- Reset then idle: all outputs at reset values. start with target=0 → done after 1 cycle, no strobe, cur=0.
- cur=0, start target=3 → three cpu low pulses of 3 cycles separated by 2-cycle gaps; cur 1,2,3; done at cycle 16; cpd stays 1.
- cur=1, start target=14 → down path chosen (dn=3 < up=13); cpd pulses ×3; cur 0,15,14 (wrap).
- cur=0, start target=8 → tie resolves up; 8 cpu pulses; cur=8.
- load_req with load_val=9 and start in the same cycle → start dropped; ld=0 for 3 cycles with dcba=9; cur=9; done. A start during busy → ignored.
- STEP_VERIFY_EN, q_fb stuck at 0, start target=2 → err=1 after the first gap; done; cur=1; no second pulse. Then rst low mid-pulse → outputs back to reset values immediately.

Source files
------------

// File: rtl/ttl74193_stepper.sv
// ---------------------------------------------------------------------------
// ttl74193_stepper
//
// Drives the CPu / CPd / CLR / /LD / D..A inputs of a 74193 up/down counter
// so that the counter reaches a requested 4-bit value. A shadow copy of the
// counter is kept in `cur`; a step request walks the shorter way around the
// mod-16 ring (a distance of 8 goes up). Every strobe is held active for
// PULSE_LOW cycles and followed by PULSE_GAP idle cycles so it survives the
// counter's input debounce.
//
// Optional feature (compile-time macro STEP_VERIFY_EN):
//   In the last cycle of every gap, q_fb is compared with the shadow value.
//   A mismatch sets the sticky err flag, abandons the remaining steps and
//   finishes the operation. Without the macro q_fb is unused and err is 0.
//
// Parameters:
//   PULSE_LOW  clk cycles a count/load/clear strobe is held active (>=1)
//   PULSE_GAP  clk cycles of idle between consecutive strobes (>=1)
//   TMR_W      phase timer width, must hold max(PULSE_LOW, PULSE_GAP)
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   start     one-cycle request to step the counter to `target`
//   target    requested counter value, sampled with start
//   load_req  one-cycle request to parallel-load `load_val`
//   load_val  value to load, sampled with load_req
//   clr_req   one-cycle request to clear the counter
//   q_fb      counter QD..QA feedback (STEP_VERIFY_EN only)
//   cpu       up-count strobe, active low
//   cpd       down-count strobe, active low
//   clr       counter clear, active high
//   ld        counter parallel load, active low
//   dcba      parallel data {D,C,B,A}
//   cur       shadow counter value
//   busy      high whenever an operation is in progress
//   done      one-cycle completion pulse
//   err       sticky step-mismatch flag
// ---------------------------------------------------------------------------
module ttl74193_stepper #(
    parameter int PULSE_LOW = 20000,
    parameter int PULSE_GAP = 20000,
    parameter int TMR_W     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] target,
    input  logic       load_req,
    input  logic [3:0] load_val,
    input  logic       clr_req,
    input  logic [3:0] q_fb,
    output logic       cpu,
    output logic       cpd,
    output logic       clr,
    output logic       ld,
    output logic [3:0] dcba,
    output logic [3:0] cur,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_STROBE,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [TMR_W-1:0] LOW_LAST = TMR_W'(PULSE_LOW - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(PULSE_GAP - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q,   tmr_d;
    logic [3:0]         cur_q,   cur_d;
    logic [3:0]         steps_q, steps_d;
    logic               up_q,    up_d;
    logic [3:0]         dcba_q,  dcba_d;
    logic               err_q,   err_d;

    // Ring distances in both directions; 4-bit subtraction gives the wrap.
    logic [3:0] dist_up;
    logic [3:0] dist_dn;
    logic       fb_mismatch;

    assign dist_up = target - cur_q;
    assign dist_dn = cur_q - target;

`ifdef STEP_VERIFY_EN
    assign fb_mismatch = (q_fb != cur_q);
`else
    logic unused_q_fb;
    assign unused_q_fb = ^q_fb;
    assign fb_mismatch = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement leaves one unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        cur_d   = cur_q;
        steps_d = steps_q;
        up_d    = up_q;
        dcba_d  = dcba_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (clr_req) begin
                    state_d = S_CLR;
                end else if (load_req) begin
                    dcba_d  = load_val;
                    state_d = S_LOAD;
                end else if (start) begin
                    if (dist_up <= dist_dn) begin
                        up_d    = 1'b1;
                        steps_d = dist_up;
                    end else begin
                        up_d    = 1'b0;
                        steps_d = dist_dn;
                    end
                    // Both distances are zero only when already at target.
                    state_d = (dist_up == 4'd0) ? S_DONE : S_STROBE;
                end
            end

            S_CLR: begin
                if (tmr_q == LOW_LAST) begin
                    tmr_d   = '0;
                    cur_d   = 4'd0;
                    steps_d = 4'd0;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_LOAD: begin
                if (tmr_q == LOW_LAST) begin
                    tmr_d   = '0;
                    cur_d   = dcba_q;
                    steps_d = 4'd0;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_STROBE: begin
                if (tmr_q == LOW_LAST) begin
                    tmr_d   = '0;
                    cur_d   = up_q ? (cur_q + 4'd1) : (cur_q - 4'd1);
                    steps_d = steps_q - 4'd1;
                    state_d = S_GAP;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_GAP: begin
                if (tmr_q == GAP_LAST) begin
                    tmr_d = '0;
                    if (fb_mismatch) begin
                        // Counter disagrees with the shadow: stop stepping.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (steps_q != 4'd0) begin
                        state_d = S_STROBE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            cur_q   <= 4'd0;
            steps_q <= 4'd0;
            up_q    <= 1'b1;
            dcba_q  <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            cur_q   <= cur_d;
            steps_q <= steps_d;
            up_q    <= up_d;
            dcba_q  <= dcba_d;
            err_q   <= err_d;
        end
    end

    // Strobes decode from the registered state only, so each one is a clean
    // level for its whole phase and the two count strobes are exclusive.
    assign cpu  = !((state_q == S_STROBE) &&  up_q);
    assign cpd  = !((state_q == S_STROBE) && !up_q);
    assign clr  = (state_q == S_CLR);
    assign ld   = !(state_q == S_LOAD);
    assign dcba = dcba_q;
    assign cur  = cur_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

`ifdef STEP_VERIFY_EN
    assign err = err_q;
`else
    assign err = 1'b0;
    logic unused_err_q;
    assign unused_err_q = err_q & err_d;
`endif

endmodule

// File: tb/tb_ttl74193_stepper.sv
// ---------------------------------------------------------------------------
// Testbench for ttl74193_stepper with PULSE_LOW=3, PULSE_GAP=2.
// Inputs are driven and outputs sampled on the falling clock edge. All
// outputs are compared as one packed vector:
//   {cpu, cpd, clr, ld, dcba[3:0], cur[3:0], busy, done, err}
// ---------------------------------------------------------------------------
module tb_ttl74193_stepper;

    localparam int PL = 3;
    localparam int PG = 2;
    localparam int PERIOD = PL + PG;
    localparam logic [14:0] RESET_OUTS = 15'h6800;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] target;
    logic       load_req;
    logic [3:0] load_val;
    logic       clr_req;
    logic [3:0] q_fb;
    logic       cpu, cpd, clr, ld, busy, done, err;
    logic [3:0] dcba, cur;

    logic       fb_stuck;
    logic [3:0] exp_dcba;
    int         checks;
    int         errors;

    wire [14:0] outs = {cpu, cpd, clr, ld, dcba, cur, busy, done, err};

    // Feedback behaves like a healthy counter unless forced stuck at zero.
    assign q_fb = fb_stuck ? 4'd0 : cur;

    always #5 clk = ~clk;

    ttl74193_stepper #(
        .PULSE_LOW (PL),
        .PULSE_GAP (PG),
        .TMR_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .target   (target),
        .load_req (load_req),
        .load_val (load_val),
        .clr_req  (clr_req),
        .q_fb     (q_fb),
        .cpu      (cpu),
        .cpd      (cpd),
        .clr      (clr),
        .ld       (ld),
        .dcba     (dcba),
        .cur      (cur),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic test_reset();
        rst      = 1'b0;
        start    = 1'b0;
        target   = 4'd0;
        load_req = 1'b0;
        load_val = 4'd0;
        clr_req  = 1'b0;
        fb_stuck = 1'b0;
        exp_dcba = 4'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs !== RESET_OUTS) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", outs, RESET_OUTS);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (outs !== RESET_OUTS) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", outs, RESET_OUTS);
        end
    endtask

    // Step from cur0 to tgt; direction and step count are supplied by the
    // caller. Checks every cycle from the one after the request up to the
    // first idle cycle after done.
    task automatic test_step(input string name, input logic [3:0] tgt,
                             input logic [3:0] cur0, input bit up, input int n);
        logic [14:0] exp;
        logic        e_low;
        logic [3:0]  e_cur;
        int          j;
        int          o;
        start  = 1'b1;
        target = tgt;
        @(negedge clk);
        start  = 1'b0;
        for (int k = 1; k <= n * PERIOD + 2; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= n * PERIOD) begin
                j     = (k - 1) / PERIOD;
                o     = (k - 1) % PERIOD;
                e_low = (o < PL);
                if (!e_low) j = j + 1;
                e_cur = up ? (cur0 + 4'(j)) : (cur0 - 4'(j));
                exp   = {up ? ~e_low : 1'b1, up ? 1'b1 : ~e_low, 1'b0, 1'b1,
                         exp_dcba, e_cur, 1'b1, 1'b0, 1'b0};
            end else if (k == n * PERIOD + 1) begin
                exp = {4'b1101, exp_dcba, tgt, 3'b110};
            end else begin
                exp = {4'b1101, exp_dcba, tgt, 3'b000};
            end
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, outs, exp);
            end
        end
    endtask

    // Load (with a same-cycle start that must be dropped) or clear (with a
    // same-cycle load that must be dropped). A start issued while busy must
    // be ignored.
    task automatic test_load_clr(input string name, input bit is_clr,
                                 input logic [3:0] val, input logic [3:0] cur0);
        logic [14:0] exp;
        logic [3:0]  e_cur;
        logic [3:0]  new_cur;
        new_cur  = is_clr ? 4'd0 : val;
        clr_req  = is_clr;
        load_req = 1'b1;
        load_val = val;
        start    = 1'b1;
        target   = 4'd5;
        @(negedge clk);
        clr_req  = 1'b0;
        load_req = 1'b0;
        start    = 1'b0;
        if (!is_clr) exp_dcba = val;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            e_cur = (k <= PL) ? cur0 : new_cur;
            if (k <= PL)
                exp = {2'b11, is_clr, is_clr, exp_dcba, e_cur, 3'b100};
            else if (k <= PERIOD)
                exp = {4'b1101, exp_dcba, e_cur, 3'b100};
            else if (k == PERIOD + 1)
                exp = {4'b1101, exp_dcba, e_cur, 3'b110};
            else
                exp = {4'b1101, exp_dcba, e_cur, 3'b000};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, outs, exp);
            end
            start  = (k == 2);
            target = 4'd7;
        end
        start = 1'b0;
    endtask

`ifdef STEP_VERIFY_EN
    task automatic test_verify();
        logic [14:0] exp;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        exp_dcba = 4'd0;
        fb_stuck = 1'b1;
        start    = 1'b1;
        target   = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= PL)          exp = {4'b0101, 4'd0, 4'd0, 3'b100};
            else if (k <= PERIOD) exp = {4'b1101, 4'd0, 4'd1, 3'b100};
            else if (k == PERIOD + 1) exp = {4'b1101, 4'd0, 4'd1, 3'b111};
            else                  exp = {4'b1101, 4'd0, 4'd1, 3'b001};
            checks++;
            if (outs !== exp) begin
                errors++;
                $display("FAIL verify cycle %0d: got %h expected %h", k, outs, exp);
            end
        end
        fb_stuck = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_pulse();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst      = 1'b1;
        exp_dcba = 4'd0;
        start    = 1'b1;
        target   = 4'd2;
        @(negedge clk);
        start    = 1'b0;
        @(negedge clk);
        checks++;
        if (outs !== 15'h2804) begin
            errors++;
            $display("FAIL mid_pulse_active: got %h expected %h", outs, 15'h2804);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== RESET_OUTS) begin
            errors++;
            $display("FAIL mid_pulse_async_reset: got %h expected %h", outs, RESET_OUTS);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (outs !== RESET_OUTS) begin
                errors++;
                $display("FAIL mid_pulse_after cycle %0d: got %h expected %h",
                         k, outs, RESET_OUTS);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_step("zero_step", 4'd0, 4'd0, 1'b1, 0);
        test_step("up_0_to_3", 4'd3, 4'd0, 1'b1, 3);
        test_load_clr("load_9", 1'b0, 4'd9, 4'd3);
        test_load_clr("clear", 1'b1, 4'd4, 4'd9);
        test_load_clr("load_1", 1'b0, 4'd1, 4'd0);
        test_step("down_1_to_14", 4'd14, 4'd1, 1'b0, 3);
        test_step("up_14_to_2_wrap", 4'd2, 4'd14, 1'b1, 4);
        test_load_clr("clear2", 1'b1, 4'd6, 4'd2);
        test_step("tie_0_to_8", 4'd8, 4'd0, 1'b1, 8);
        test_step("same_8", 4'd8, 4'd8, 1'b1, 0);
`ifdef STEP_VERIFY_EN
        test_verify();
`endif
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
